// File: rtl/key_event_queue_if.sv
// Consumer-side event handshake of the keypad event queue.
// The queue drives the head event (master); the terminal controller accepts it (slave).
interface key_event_queue_if #(
  parameter int CODE_W = 3
);
  logic              EvValid;
  logic [CODE_W-1:0] EvCode;
  logic              EvRepeat;
  logic              EvReady;

  modport master (
    output EvValid,
    output EvCode,
    output EvRepeat,
    input  EvReady
  );

  modport slave (
    input  EvValid,
    input  EvCode,
    input  EvRepeat,
    output EvReady
  );
endinterface

// File: rtl/key_event_queue.sv
// Keypad event queue for the sale terminal.
// Turns debounced key levels into press events (one per rising edge) plus
// auto-repeat events for the most recently pressed key while it stays held,
// and buffers them in a small first-word-fall-through FIFO for the controller.
module key_event_queue #(
  parameter int NUM_KEYS      = 8,
  parameter int CODE_W        = 3,
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter int CNT_W         = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_KEYS-1:0]           KeyLevel,
  key_event_queue_if.master             ev,
  output logic [$clog2(FIFO_DEPTH):0]   FifoCount,
  output logic                          Overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam int ENT_W  = CODE_W + 1;

  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  REP_LAST   = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_FW-1:0] DEPTH_FULL = CNT_FW'(FIFO_DEPTH);

  // Elaboration-time guards on parameter combinations the logic relies on.
  if ((2 ** CODE_W) < NUM_KEYS) begin : g_chk_code
    $error("key_event_queue: CODE_W too narrow for NUM_KEYS");
  end
  if ((HOLD_CYCLES < 2) || (REPEAT_CYCLES < 2)) begin : g_chk_timing
    $error("key_event_queue: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
  end
  if ((2 ** PTR_W) != FIFO_DEPTH || FIFO_DEPTH < 2) begin : g_chk_depth
    $error("key_event_queue: FIFO_DEPTH must be a power of two >= 2");
  end
  if (((2 ** CNT_W) <= HOLD_CYCLES) || ((2 ** CNT_W) <= REPEAT_CYCLES)) begin : g_chk_cnt
    $error("key_event_queue: CNT_W too narrow for hold/repeat periods");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Key edge detection and pending press mask
  logic [NUM_KEYS-1:0] key_prev_q;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [NUM_KEYS-1:0] press;

  // Hold / repeat tracking of the last pressed key
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   track_q, track_d;
  logic                rep_pend_q, rep_pend_d;

  // Push arbiter results
  logic                pend_hit;
  logic [CODE_W-1:0]   pend_idx;
  logic [NUM_KEYS-1:0] grant_oh;
  logic                push_valid;
  logic                push_rep;
  logic [CODE_W-1:0]   push_code;
  logic                key_rel;

  // Event FIFO
  logic [ENT_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_FW-1:0]   count_q, count_d;
  logic                ovf_q;
  logic                pop;
  logic                push_ok;
  logic                drop;
  logic [ENT_W-1:0]    head;

  assign press   = KeyLevel & ~key_prev_q;
  assign key_rel = ~KeyLevel[track_q];

  // Arbiter: pick the lowest-index pending press; a repeat only goes when no press waits.
  always_comb begin
    pend_hit = 1'b0;
    pend_idx = '0;
    grant_oh = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        pend_hit = 1'b1;
        pend_idx = CODE_W'(i);
      end
    end
    if (pend_hit) begin
      grant_oh[pend_idx] = 1'b1;
    end
    push_valid = pend_hit | rep_pend_q;
    push_rep   = ~pend_hit;
    push_code  = pend_hit ? pend_idx : track_q;
  end

  // Pending mask: attempted key leaves the mask; a fresh rising edge (re)arms it.
  always_comb begin
    pending_d = (pending_q & ~grant_oh) | press;
  end

  // Hold/repeat next state: a press push restarts timing on that key and beats a release.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    track_d    = track_q;
    rep_pend_d = rep_pend_q & pend_hit;   // a repeat attempt happens only when no press is pending
    if (pend_hit) begin
      state_d = S_HOLD;
      track_d = pend_idx;
      cnt_d   = '0;
    end else if (key_rel) begin
      state_d    = S_IDLE;
      rep_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rep_pend_d = 1'b1;
            cnt_d      = '0;
            state_d    = S_REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (cnt_q == REP_LAST) begin
            rep_pend_d = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FIFO control: a full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    pop     = (count_q != '0) & ev.EvReady;
    push_ok = push_valid & ((count_q != DEPTH_FULL) | pop);
    drop    = push_valid & ~push_ok;
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control registers: edge history, pending mask, repeat timing, FIFO pointers, sticky overflow.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_prev_q <= '0;
      pending_q  <= '0;
      cnt_q      <= '0;
      track_q    <= '0;
      rep_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      key_prev_q <= KeyLevel;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      track_q    <= track_d;
      rep_pend_q <= rep_pend_d;
      count_q    <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Event storage: payload only, never read while empty so it needs no reset.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= {push_rep, push_code};
    end
  end

  // Head presentation: zeroed when empty, otherwise held until popped.
  always_comb begin
    head        = mem[rd_ptr_q];
    ev.EvValid  = (count_q != '0);
    ev.EvCode   = ev.EvValid ? head[CODE_W-1:0] : '0;
    ev.EvRepeat = ev.EvValid ? head[CODE_W] : 1'b0;
    FifoCount   = count_q;
    Overflow    = ovf_q;
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue with a queue-based reference model.
module tb_key_event_queue;

  localparam int NK    = 8;
  localparam int CW    = 3;
  localparam int HOLD  = 8;
  localparam int REP   = 4;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [NK-1:0] KeyLevel = '0;
  logic [2:0]    FifoCount;
  logic          Overflow;

  int n_tests = 0;
  int n_fail  = 0;

  key_event_queue_if #(.CODE_W(CW)) ev ();

  key_event_queue #(
    .NUM_KEYS(NK), .CODE_W(CW), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
    .CNT_W(16), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .KeyLevel(KeyLevel), .ev(ev),
    .FifoCount(FifoCount), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  // Reference model: pending keys as a mask, events as a queue, repeat timing by age.
  logic [NK-1:0] m_prev, m_pend;
  bit            m_rep, m_active, m_ovf;
  int            m_track, m_push_t, m_t;
  logic [3:0]    m_q[$];

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_rep = 0; m_active = 0; m_ovf = 0;
    m_track = 0; m_push_t = 0; m_q.delete();
  endtask

  function automatic bit repeat_due(int age);
    return (age >= HOLD) && (((age - HOLD) % REP) == 0);
  endfunction

  task automatic model_edge();
    logic [NK-1:0] prs;
    logic [3:0]    ent;
    bit            att, att_rep, pp, acc;
    int            k;
    prs = KeyLevel & ~m_prev;
    k = -1;
    for (int i = 0; i < NK; i++) if (m_pend[i] && k < 0) k = i;
    att = 0; att_rep = 0; ent = '0;
    if (k >= 0) begin att = 1; ent = {1'b0, 3'(k)}; end
    else if (m_rep) begin att = 1; att_rep = 1; ent = {1'b1, 3'(m_track)}; end
    pp  = (m_q.size() > 0) && ev.EvReady;
    acc = att && ((m_q.size() < DEPTH) || pp);
    if (att && !acc) m_ovf = 1;
    if (k >= 0) m_pend[k] = 1'b0;
    m_pend |= prs;
    if (att_rep) m_rep = 0;
    if (k >= 0) begin m_active = 1; m_track = k; m_push_t = m_t; end
    else if (!KeyLevel[m_track]) begin m_active = 0; m_rep = 0; end
    else if (m_active && repeat_due(m_t - m_push_t)) m_rep = 1;
    if (pp) void'(m_q.pop_front());
    if (acc) m_q.push_back(ent);
    m_prev = KeyLevel;
    m_t++;
  endtask

  function automatic logic [8:0] model_word();
    logic [3:0] hd;
    hd = (m_q.size() > 0) ? m_q[0] : 4'd0;
    return {m_q.size() > 0, hd[2:0], hd[3], 3'(m_q.size()), m_ovf};
  endfunction

  function automatic logic [8:0] dut_word();
    return {ev.EvValid, ev.EvCode, ev.EvRepeat, FifoCount, Overflow};
  endfunction

  // One clock edge: the model consumes the same inputs the DUT sampled; outputs settle by +1.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; ev.EvReady = 1'b0; KeyLevel = '0;
    model_reset();
    #12;
    n_tests++;
    if (dut_word() !== 9'h000) begin
      n_fail++; $display("FAIL reset_state: got %h required %h", dut_word(), 9'h000);
    end
    @(negedge CLK); RST_N = 1'b1;
  endtask

  task automatic test_single_press();
    ev.EvReady = 1'b1; KeyLevel = '0;
    step();
    KeyLevel[3] = 1'b1;
    step();
    n_tests++;
    if (ev.EvValid !== 1'b0) begin
      n_fail++; $display("FAIL t1_not_yet: valid got %b required 0", ev.EvValid);
    end
    step();
    n_tests++;
    if ({ev.EvValid, ev.EvCode, ev.EvRepeat} !== {1'b1, 3'd3, 1'b0}) begin
      n_fail++; $display("FAIL t1_press: got v%b c%0d r%b required v1 c3 r0", ev.EvValid, ev.EvCode, ev.EvRepeat);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (ev.EvValid !== 1'b0 || dut_word() !== model_word()) begin
        n_fail++; $display("FAIL t1_quiet[%0d]: got %h required %h", i, dut_word(), model_word());
      end
    end
    KeyLevel[3] = 1'b0;
    step();
  endtask

  task automatic test_repeat();
    int nrep;
    nrep = 0;
    ev.EvReady = 1'b1; KeyLevel = '0;
    step();
    KeyLevel[5] = 1'b1;
    step();
    step();
    n_tests++;
    if ({ev.EvValid, ev.EvCode, ev.EvRepeat} !== {1'b1, 3'd5, 1'b0}) begin
      n_fail++; $display("FAIL t2_press: got v%b c%0d r%b required v1 c5 r0", ev.EvValid, ev.EvCode, ev.EvRepeat);
    end
    for (int i = 1; i <= 40; i++) begin
      if (i == 31) KeyLevel[5] = 1'b0;
      step();
      if (ev.EvValid && ev.EvRepeat && ev.EvCode == 3'd5) nrep++;
      n_tests++;
      if (dut_word() !== model_word()) begin
        n_fail++; $display("FAIL t2_cycle[%0d]: got %h required %h", i, dut_word(), model_word());
      end
      if (i == 9) begin
        n_tests++;
        if (!(ev.EvValid && ev.EvRepeat)) begin
          n_fail++; $display("FAIL t2_first_repeat: got v%b r%b required v1 r1", ev.EvValid, ev.EvRepeat);
        end
      end
    end
    n_tests++;
    if (nrep != 6) begin
      n_fail++; $display("FAIL t2_repeat_count: got %0d required 6", nrep);
    end
  endtask

  task automatic test_simultaneous();
    int exp_code[3] = '{1, 2, 6};
    ev.EvReady = 1'b1; KeyLevel = '0;
    step();
    KeyLevel = 8'b0100_0110;
    step();
    for (int j = 0; j < 3; j++) begin
      step();
      n_tests++;
      if ({ev.EvValid, ev.EvCode, ev.EvRepeat} !== {1'b1, 3'(exp_code[j]), 1'b0}) begin
        n_fail++; $display("FAIL t3_order[%0d]: got v%b c%0d r%b required v1 c%0d r0", j, ev.EvValid, ev.EvCode, ev.EvRepeat, exp_code[j]);
      end
    end
    KeyLevel = '0;
    step();
    step();
  endtask

  task automatic test_full_pop();
    int exp_code[4] = '{1, 2, 3, 7};
    ev.EvReady = 1'b0; KeyLevel = '0;
    for (int k = 0; k < 4; k++) begin
      KeyLevel = NK'(1) << k; step();
      KeyLevel = '0;          step();
    end
    step();
    n_tests++;
    if (FifoCount !== 3'd4 || Overflow !== 1'b0) begin
      n_fail++; $display("FAIL t5_fill: got cnt%0d ovf%b required cnt4 ovf0", FifoCount, Overflow);
    end
    KeyLevel = 8'h80;
    step();
    ev.EvReady = 1'b1; KeyLevel = '0;
    step();
    n_tests++;
    if (FifoCount !== 3'd4 || Overflow !== 1'b0 || ev.EvCode !== 3'd1) begin
      n_fail++; $display("FAIL t5_push_pop: got cnt%0d ovf%b c%0d required cnt4 ovf0 c1", FifoCount, Overflow, ev.EvCode);
    end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (ev.EvValid !== 1'b1 || ev.EvCode !== 3'(exp_code[j]) || dut_word() !== model_word()) begin
        n_fail++; $display("FAIL t5_drain[%0d]: got %h required code %0d model %h", j, dut_word(), exp_code[j], model_word());
      end
      step();
    end
    n_tests++;
    if (ev.EvValid !== 1'b0) begin
      n_fail++; $display("FAIL t5_empty: valid got %b required 0", ev.EvValid);
    end
  endtask

  task automatic test_overflow();
    ev.EvReady = 1'b0; KeyLevel = '0;
    for (int k = 0; k < 6; k++) begin
      KeyLevel = NK'(1) << k; step();
      KeyLevel = '0;          step();
    end
    step();
    n_tests++;
    if (FifoCount !== 3'd4 || Overflow !== 1'b1 || dut_word() !== model_word()) begin
      n_fail++; $display("FAIL t4_overflow: got %h cnt%0d ovf%b required cnt4 ovf1", dut_word(), FifoCount, Overflow);
    end
    n_tests++;
    if (ev.EvCode !== 3'd0) begin
      n_fail++; $display("FAIL t4_stable: code got %0d required 0", ev.EvCode);
    end
    ev.EvReady = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (ev.EvValid !== 1'b1 || ev.EvCode !== 3'(j) || ev.EvRepeat !== 1'b0) begin
        n_fail++; $display("FAIL t4_drain[%0d]: got v%b c%0d r%b required v1 c%0d r0", j, ev.EvValid, ev.EvCode, ev.EvRepeat, j);
      end
      step();
    end
    n_tests++;
    if (ev.EvValid !== 1'b0 || Overflow !== 1'b1) begin
      n_fail++; $display("FAIL t4_after: got v%b ovf%b required v0 ovf1", ev.EvValid, Overflow);
    end
  endtask

  task automatic test_reset_midcycle();
    int nev;
    logic [3:0] seen;
    nev = 0; seen = '0;
    ev.EvReady = 1'b0; KeyLevel = '0;
    KeyLevel[0] = 1'b1; step(); KeyLevel[0] = 1'b0; step();
    KeyLevel[1] = 1'b1; step(); KeyLevel[1] = 1'b0; step();
    KeyLevel[4] = 1'b1;
    n_tests++;
    if (FifoCount === 3'd0) begin
      n_fail++; $display("FAIL t6_queued: got cnt%0d required nonzero", FifoCount);
    end
    #2 RST_N = 1'b0;
    #1;
    n_tests++;
    if (dut_word() !== 9'h000) begin
      n_fail++; $display("FAIL t6_async_clear: got %h required %h", dut_word(), 9'h000);
    end
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1; ev.EvReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ev.EvValid) begin nev++; seen = {ev.EvRepeat, ev.EvCode}; end
      n_tests++;
      if (dut_word() !== model_word()) begin
        n_fail++; $display("FAIL t6_cycle[%0d]: got %h required %h", i, dut_word(), model_word());
      end
    end
    n_tests++;
    if (nev != 1 || seen !== 4'd4) begin
      n_fail++; $display("FAIL t6_one_event: got %0d events last %h required 1 event 4", nev, seen);
    end
    KeyLevel = '0;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < NK; k++) if ($urandom_range(19) == 0) KeyLevel[k] = ~KeyLevel[k];
      if (c < 400) ev.EvReady = ($urandom_range(3) != 0);
      else         ev.EvReady = ($urandom_range(4) == 0);
      step();
      n_tests++;
      if (dut_word() !== model_word()) begin
        n_fail++; $display("FAIL rand[%0d]: got %h required %h", c, dut_word(), model_word());
      end
    end
  endtask

  initial begin
    model_reset();
    m_t = 0;
    test_reset();
    test_single_press();
    test_repeat();
    test_simultaneous();
    test_full_pop();
    test_overflow();
    test_reset_midcycle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
